// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   Debounces three pushbuttons. Each raw level goes through a 2-flop
//   synchronizer. A shared prescaler produces a 1 ms strobe. An independent
//   4-state FSM per button accepts a new level only after it has held for
//   DEBOUNCE_MS strobes. The first strobe is partial, so acceptance takes
//   between (DEBOUNCE_MS-1) ms and DEBOUNCE_MS ms after the synced edge.
//
//   Parameters
//     CLK_HZ       iClk frequency in Hz
//     DEBOUNCE_MS  stable time in ms, legal range 1..31
//
//   Ports
//     iClk             clock, rising edge
//     iRst             asynchronous active-high reset
//     iButtonsRaw[2:0] raw button levels (bit n = button n)
//     oButtonsPressed  debounced levels, 1 = pressed (registered)
//     oButtonsRose     one-cycle pulse on each accepted 0->1 (registered)
//     oTickMs          1 ms strobe, exported for debug
//
//   Optional build macro
//     BUTTONS_ACTIVE_LOW_EN  raw inputs are active-low (board KEYs, 0 = pressed).
//                            The inputs are inverted ahead of the synchronizer.
// ----------------------------------------------------------------------------

// Per-button qualification FSM. sync_in is already synchronized and active-high.
module button_debounce_lane #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    input  logic tick,
    output logic pressed,
    output logic rose
);
    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(DEBOUNCE_MS - 1);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       pressed_q, pressed_d;
    logic       rose_q, rose_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            rose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            rose_q    <= rose_d;
        end
    end

    // The counter stops at CNT_LAST. The tick seen at CNT_LAST causes the
    // transition instead of an increment, so the counter cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (sync_in) begin
                    state_d = PRESS_PENDING;
                    cnt_d   = '0;
                end
            end
            PRESS_PENDING: begin
                if (!sync_in) begin
                    state_d = RELEASED;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) state_d = PRESSED;
                    else                   cnt_d   = cnt_q + 5'd1;
                end
            end
            PRESSED: begin
                if (!sync_in) begin
                    state_d = RELEASE_PENDING;
                    cnt_d   = '0;
                end
            end
            RELEASE_PENDING: begin
                if (sync_in) begin
                    state_d = PRESSED;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) state_d = RELEASED;
                    else                   cnt_d   = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        // The outputs are registered from the next state, so they track the
        // FSM state register with no extra cycle of lag.
        pressed_d = (state_d == PRESSED) || (state_d == RELEASE_PENDING);
        // Only a qualification from PRESS_PENDING fires the pulse. A glitch
        // that returns from RELEASE_PENDING does not fire it.
        rose_d    = (state_q == PRESS_PENDING) && (state_d == PRESSED);
    end

    assign pressed = pressed_q;
    assign rose    = rose_q;
endmodule

module button_debounce #(
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [2:0] iButtonsRaw,
    output logic [2:0] oButtonsPressed,
    output logic [2:0] oButtonsRose,
    output logic       oTickMs
);
    localparam int NUM_BTN  = 3;
    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

    // Inversion happens before the synchronizer. The synced domain is
    // therefore always active-high, and the released level after reset is 0
    // in both builds.
    logic [NUM_BTN-1:0] btn_in;
`ifdef BUTTONS_ACTIVE_LOW_EN
    assign btn_in = ~iButtonsRaw;
`else
    assign btn_in = iButtonsRaw;
`endif

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [PW-1:0]      ps_q, ps_d;
    logic               tick;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            ps_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            ps_q    <= ps_d;
        end
    end

    assign tick = (ps_q == PS_MAX);

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        ps_d    = tick ? '0 : ps_q + PW'(1);
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_lane
            button_debounce_lane #(
                .DEBOUNCE_MS(DEBOUNCE_MS)
            ) u_lane (
                .clk    (iClk),
                .rst    (iRst),
                .sync_in(sync2_q[g]),
                .tick   (tick),
                .pressed(oButtonsPressed[g]),
                .rose   (oButtonsRose[g])
            );
        end
    endgenerate

    assign oTickMs = tick;
endmodule

// File: tb/tb_button_debounce.sv
// Directed bench: CLK_HZ=10000 (10 cycles/ms), DEBOUNCE_MS=3.
// Stimulus is written as "pressed" patterns and mapped to raw polarity, so
// the same vectors work with or without BUTTONS_ACTIVE_LOW_EN.
module tb_button_debounce;
    logic       iClk = 1'b0;
    logic       iRst;
    logic [2:0] iButtonsRaw;
    logic [2:0] oButtonsPressed;
    logic [2:0] oButtonsRose;
    logic       oTickMs;

`ifdef BUTTONS_ACTIVE_LOW_EN
    localparam logic [2:0] POL = 3'b111;
`else
    localparam logic [2:0] POL = 3'b000;
`endif

    button_debounce #(
        .CLK_HZ     (10000),
        .DEBOUNCE_MS(3)
    ) dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iButtonsRaw    (iButtonsRaw),
        .oButtonsPressed(oButtonsPressed),
        .oButtonsRose   (oButtonsRose),
        .oTickMs        (oTickMs)
    );

    always #5 iClk = ~iClk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-window observation state, updated once per cycle by step().
    int         cyc, lat, rose_cnt, tick_cnt;
    logic [2:0] base, first_val, rose_val;

    task automatic clr(input logic [2:0] b);
        base = b; cyc = 0; lat = 0; first_val = b;
        rose_cnt = 0; rose_val = '0; tick_cnt = 0;
    endtask

    task automatic step();
        @(posedge iClk); #1;
        cyc++;
        if (lat == 0 && oButtonsPressed !== base) begin
            lat       = cyc;
            first_val = oButtonsPressed;
        end
        if (oButtonsRose != 3'b000) begin
            rose_cnt++;
            rose_val |= oButtonsRose;
        end
        if (oTickMs) tick_cnt++;
    endtask

    task automatic drive(input logic [2:0] pat);
        iButtonsRaw = POL ^ pat;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        iRst = 1'b1;
        drive(3'b000);
        repeat (3) @(posedge iClk);
        #1;
        check("rst_pressed", oButtonsPressed, 3'b000);
        check("rst_rose",    oButtonsRose,    3'b000);
        check("rst_tick",    oTickMs,         1'b0);
        iRst = 1'b0;

        // Idle input: one tick every 10 cycles, and nothing is pressed.
        clr(3'b000);
        steps(100);
        check("tick_count", tick_cnt, 10);
        check("idle_no_press", lat, 0);

        // Clean press of button 1.
        drive(3'b010);
        clr(3'b000);
        steps(100);
        check("clean_lat_23_33", (lat >= 23 && lat <= 33), 1);
        check("clean_val", first_val, 3'b010);
        check("clean_rose_cnt", rose_cnt, 1);
        check("clean_rose_val", rose_val, 3'b010);
        drive(3'b000);
        clr(3'b010);
        steps(60);
        check("clean_release", first_val, 3'b000);
        check("release_no_rose", rose_cnt, 0);

        // Bounce on button 0: 5-cycle high/low, which is never long enough.
        clr(3'b000);
        for (int k = 0; k < 12; k++) begin
            drive((k % 2 == 0) ? 3'b001 : 3'b000);
            steps(5);
        end
        drive(3'b000);
        steps(40);
        check("bounce_no_press", lat, 0);
        check("bounce_no_rose", rose_cnt, 0);

        // Release glitch on button 2.
        drive(3'b100);
        clr(3'b000);
        steps(50);
        check("glitch_press_val", first_val, 3'b100);
        check("glitch_press_rose", rose_cnt, 1);
        clr(3'b100);
        drive(3'b000);
        steps(15);
        drive(3'b100);
        steps(40);
        check("glitch_held", lat, 0);
        check("glitch_no_rerose", rose_cnt, 0);
        drive(3'b000);
        steps(60);

        // Simultaneous press of buttons 2 and 0.
        drive(3'b101);
        clr(3'b000);
        steps(60);
        check("simul_val", first_val, 3'b101);
        check("simul_rose_val", rose_val, 3'b101);
        check("simul_rose_cnt", rose_cnt, 1);
        drive(3'b000);
        steps(60);

        // Reset while button 0 is accepted and held.
        drive(3'b001);
        clr(3'b000);
        steps(50);
        check("rstmid_pre", first_val, 3'b001);
        iRst = 1'b1;
        #1;
        check("rstmid_async", oButtonsPressed, 3'b000);
        steps(2);
        iRst = 1'b0;
        clr(3'b000);
        steps(60);
        check("rstmid_lat_23_33", (lat >= 23 && lat <= 33), 1);
        check("rstmid_val", first_val, 3'b001);
        check("rstmid_rose", rose_cnt, 1);
        drive(3'b000);
        steps(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, giving the iClk frequency in Hz.
REQ-002 The block SHALL have parameter DEBOUNCE_MS, default 20, giving the stable time in ms that a level must hold before it is accepted (legal range 1..31).
REQ-003 The block SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port iRst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port iButtonsRaw, input, 3 bits: raw pushbutton levels; bit2 is button 2, bit1 is button 1, bit0 is button 0.
REQ-006 The block SHALL have port oButtonsPressed, output, 3 bits: debounced levels, 1 meaning pressed, in the same bit order; this feeds the reaction FSM's pressed-buttons input.
REQ-007 The block SHALL have port oButtonsRose, output, 3 bits: a one-cycle pulse per bit when that bit of oButtonsPressed goes 0->1.
REQ-008 The block SHALL have port oTickMs, output, 1 bit: the internal 1 ms strobe, exported for debug.

Function
REQ-009 Each iButtonsRaw bit SHALL pass through a 2-flop synchronizer before any use; the raw-to-synced latency is 2 cycles.
REQ-010 A prescaler SHALL count 0..(CLK_HZ/1000 - 1), wrap to 0, and assert oTickMs for exactly 1 cycle when the count equals the maximum.
REQ-011 Each button SHALL have an independent 4-state FSM: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
REQ-012 In RELEASED, a synced 1 SHALL move the FSM to PRESS_PENDING and clear that button's 5-bit ms counter.
REQ-013 In PRESS_PENDING, a synced 0 SHALL return the FSM to RELEASED; otherwise each tick increments the counter.
REQ-014 In PRESS_PENDING, a tick while the counter equals DEBOUNCE_MS-1 SHALL move the FSM to PRESSED.
REQ-015 In PRESSED, a synced 0 SHALL move the FSM to RELEASE_PENDING and clear the counter.
REQ-016 In RELEASE_PENDING, a synced 1 SHALL return the FSM to PRESSED; otherwise it counts ticks as in REQ-013 and REQ-014 and enters RELEASED on completion.
REQ-017 An oButtonsPressed bit SHALL be registered and SHALL be 1 exactly while its FSM is in PRESSED or RELEASE_PENDING.
REQ-018 An oButtonsRose bit SHALL be registered and SHALL be high for the single cycle after its FSM enters PRESSED from PRESS_PENDING; it never re-fires on a RELEASE_PENDING->PRESSED return.
REQ-019 Acceptance delay from synced edge to output change SHALL lie between (DEBOUNCE_MS-1)*CLK_HZ/1000+1 and DEBOUNCE_MS*CLK_HZ/1000+1 cycles, because the first tick is partial.
REQ-020 Buttons SHALL be fully independent: simultaneous presses produce multi-bit patterns (e.g. 3'b011), with no priority or masking.
REQ-021 The ms counters SHALL never wrap: with DEBOUNCE_MS at most 31, the counter cannot exceed DEBOUNCE_MS-1 before a transition.

Reset
REQ-022 While iRst=1, asynchronously: every FSM SHALL be in RELEASED; counters, prescaler and synchronizer flops SHALL be 0; oButtonsPressed=000, oButtonsRose=000, oTickMs=0.
REQ-023 Reset asserted mid-press SHALL drop oButtonsPressed to 000 immediately; after release, a still-held button SHALL be re-qualified with a full debounce period and SHALL pulse oButtonsRose.

Configuration
REQ-024 With macro BUTTONS_ACTIVE_LOW_EN defined, iButtonsRaw SHALL be inverted ahead of the synchronizer (board KEYs, 0 = pressed), and the synchronizer flops SHALL reset to the released level.
REQ-025 With BUTTONS_ACTIVE_LOW_EN undefined, iButtonsRaw SHALL be active-high (1 = pressed); all other behaviour is identical.

Verification (CLK_HZ=10000, i.e. 10 cycles/ms; DEBOUNCE_MS=3; macro undefined unless stated)
REQ-026 Clean press: iButtonsRaw=010 held 100 cycles -> oButtonsPressed=010 between 23 and 33 cycles after the edge; oButtonsRose=010 for exactly 1 cycle.
REQ-027 Bounce: bit0 toggles every 5 cycles for 60 cycles, then held 0 -> oButtonsPressed stays 000 and oButtonsRose never pulses.
REQ-028 Release glitch: button 2 held pressed, then a 0 for 15 cycles, then 1 -> oButtonsPressed stays 100 throughout, with no second oButtonsRose pulse.
REQ-029 Simultaneous press: 101 applied in one cycle -> oButtonsPressed goes 000->101 in the same cycle, and oButtonsRose=101 for 1 cycle.
REQ-030 Reset mid-press: iRst pulsed for 2 cycles while 001 is accepted and held -> output 000 within the reset cycle, back to 001 23-33 cycles after iRst falls, with an oButtonsRose pulse.
REQ-031 Active-low: with BUTTONS_ACTIVE_LOW_EN defined, idle input 111 gives oButtonsPressed=000, and driving 110 gives 001 after debounce.
